// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_add_ctrl
//  Description : Digit-serial packed-BCD adder controller, one decimal digit
//                per clock, LSD first, with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry,
    output logic                err,
    output logic                busy
);

    localparam int              c_width = 4 * DIGITS;
    localparam int              c_cnt_w = $clog2(DIGITS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIGITS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_width-1:0] r_a_sr;
    logic [c_width-1:0] r_b_sr;
    logic [c_width-1:0] r_result;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_err;

    logic [4:0] w_raw;
    logic [4:0] w_adj;
    logic       w_fix;
    logic [3:0] w_digit;
    logic       w_bad;

    // Single digit stage: binary add then +6 correction when the raw sum exceeds 9.
    always_comb begin
        w_raw   = {1'b0, r_a_sr[3:0]} + {1'b0, r_b_sr[3:0]} + {4'b0000, r_carry};
        w_adj   = w_raw + 5'd6;
        w_fix   = (w_raw > 5'd9);
        w_digit = w_fix ? w_adj[3:0] : w_raw[3:0];
        w_bad   = (r_a_sr[3:0] > 4'd9) | (r_b_sr[3:0] > 4'd9);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (in_valid) w_state_nxt = c_run;
            c_run:   if (r_cnt == c_last) w_state_nxt = c_done;
            c_done:  if (out_ready) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                    end
                end
                c_run: begin
                    // Result fills from the MSD end so digit 0 lands in [3:0] after DIGITS shifts.
                    r_result <= {w_digit, r_result[c_width-1:4]};
                    r_a_sr   <= {4'b0000, r_a_sr[c_width-1:4]};
                    r_b_sr   <= {4'b0000, r_b_sr[c_width-1:4]};
                    r_carry  <= w_fix;
                    r_err    <= r_err | w_bad;
                    if (r_cnt != c_last) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign busy      = (r_state != c_idle);
    assign sum       = r_result;
    assign carry     = r_carry;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_add_ctrl
//  Description : Self-checking bench for bcd_serial_add_ctrl (DIGITS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry;
    logic        err;
    logic        busy;

    int checks;
    int errors;

    bcd_serial_add_ctrl #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        carry;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal integer arithmetic for legal operands, digit rule only when a digit is illegal.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                         output logic [15:0] ms, output logic mcar, output logic merr);
        int ta, tb, tot, c, raw;
        merr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) merr = 1'b1;
        end
        ms = '0;
        if (!merr) begin
            ta = 0;
            tb = 0;
            for (int i = 3; i >= 0; i--) begin
                ta = ta * 10 + int'(ma[4*i +: 4]);
                tb = tb * 10 + int'(mb[4*i +: 4]);
            end
            tot  = ta + tb + int'(mc);
            mcar = (tot >= 10000);
            tot  = tot % 10000;
            for (int i = 0; i < 4; i++) begin
                ms[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(mc);
            for (int i = 0; i < 4; i++) begin
                raw = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + c;
                if (raw > 9) begin
                    raw = raw + 6;
                    c = 1;
                end else begin
                    c = 0;
                end
                ms[4*i +: 4] = 4'(raw % 16);
            end
            mcar = c[0];
        end
    endtask

    // One full transaction; poke drives a competing operand during the DONE stall.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input int stall, input logic poke,
                          output logic [15:0] s, output logic c, output logic e, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        check("busy_in_run", {30'd0, busy, in_ready}, 32'd2);
        lat = 1;
        while (!out_valid && lat < 30) begin
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        s = sum; c = carry; e = err;
        for (int k = 0; k < stall; k++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            check("hold_in_done", {12'd0, out_valid, in_ready, c, e, sum}, {12'd0, 1'b1, 1'b0, c, e, s});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_xfer", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    vec_t        vecs[10];
    logic [15:0] rs, es;
    logic        rc, re, ec, ee;
    int          lat;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0909, 16'h0191, 1'b0, 16'h1100, 1'b0, 1'b0};
        vecs[8] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {27'd0, in_ready, out_valid, busy, carry, err}, 32'h10);
        check("reset_sum", {16'd0, sum}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, rs, rc, re, lat);
            check("vec_sum", {16'd0, rs}, {16'd0, vecs[i].sum});
            check("vec_carry_err", {30'd0, rc, re}, {30'd0, vecs[i].carry, vecs[i].err});
            check("vec_latency", lat, 5);
        end

        // Long stall in DONE with a competing in_valid that must be ignored.
        run_op(16'h1234, 16'h5678, 1'b0, 10, 1'b1, rs, rc, re, lat);
        check("stall_sum", {16'd0, rs}, 32'h6912);
        check("stall_carry_err", {30'd0, rc, re}, 32'd0);
        check("stall_not_busy", {31'd0, busy}, 32'd0);

        // Reset on the second RUN cycle discards the operation.
        a = 16'h9999; b = 16'h9999; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_flags", {27'd0, in_ready, out_valid, busy, carry, err}, 32'h10);
        check("midrun_rst_sum", {16'd0, sum}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("no_ghost_result", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, rs, rc, re, lat);
        check("after_rst_sum", {16'd0, rs}, 32'h0002);
        check("after_rst_latency", lat, 5);

        // Randomized operands, mostly legal digits, against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic [15:0] ra, rb;
            logic        rcin;
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            rcin = 1'($urandom);
            model(ra, rb, rcin, es, ec, ee);
            run_op(ra, rb, rcin, $urandom_range(0, 3), 1'b0, rs, rc, re, lat);
            check("rand_sum", {16'd0, rs}, {16'd0, es});
            check("rand_carry_err", {30'd0, rc, re}, {30'd0, ec, ee});
            check("rand_latency", lat, 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
